// File: rtl/audio_dac_tx.sv
// Audio sample FIFO feeding an MSB-first SPI-style DAC serialiser.
// Reports completion once the datapath has finished and all queued audio is out.
module audio_dac_tx #(
    parameter int DATA_W  = 11,
    parameter int DEPTH   = 16,
    parameter int CLK_DIV = 2,
    parameter int FRAME_W = 16
) (
    input  logic              clkFPGA,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic              finish_in,
    output logic              dac_sclk,
    output logic              dac_mosi,
    output logic              dac_cs_n,
    output logic              busy,
    output logic              overflow,
    output logic              done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_W - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               full, empty, wr_en, pop;
    logic               fin_latch, ovf_q, done_q;

    state_t             state, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [BW-1:0]      bit_cnt, bit_cnt_d;
    logic [DW-1:0]      div_cnt, div_cnt_d;
    logic               sclk_q, sclk_d, cs_n_q, cs_n_d, mosi_q, mosi_d;

    // Ready comes from the registered count, so a full FIFO refuses a write even if a pop lands on the same edge
    assign full         = (count == CNT_FULL);
    assign empty        = (count == '0);
    assign sample_ready = !full;
    assign wr_en        = sample_valid && !full;

    assign dac_sclk = sclk_q;
    assign dac_mosi = mosi_q;
    assign dac_cs_n = cs_n_q;
    assign busy     = (state != IDLE);
    assign overflow = ovf_q;
    assign done     = done_q;

    always_ff @(posedge clkFPGA) begin
        if (wr_en) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clkFPGA) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf_q     <= 1'b0;
            fin_latch <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (sample_valid && full) ovf_q <= 1'b1;
            if (finish_in) fin_latch <= 1'b1;
            done_q <= fin_latch && empty && (state == IDLE);
        end
    end

    always_comb begin
        state_d   = state;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt;
        div_cnt_d = div_cnt;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        mosi_d    = mosi_q;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = FRAME_W'(mem[rd_ptr]);
                    cs_n_d    = 1'b0;
                    sclk_d    = 1'b0;
                    mosi_d    = shift_d[FRAME_W-1];
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_d = '0;
                    sclk_d    = !sclk_q;
                    // Falling sclk: either advance to the next bit or close the frame
                    if (sclk_q) begin
                        if (bit_cnt == BIT_LAST) begin
                            state_d = GAP;
                            cs_n_d  = 1'b1;
                            sclk_d  = 1'b0;
                            mosi_d  = 1'b0;
                        end else begin
                            shift_d   = shift_q << 1;
                            mosi_d    = shift_d[FRAME_W-1];
                            bit_cnt_d = bit_cnt + 1'b1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt + 1'b1;
                end
            end
            GAP: begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    div_cnt_d = div_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkFPGA) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            div_cnt <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            state   <= state_d;
            bit_cnt <= bit_cnt_d;
            div_cnt <= div_cnt_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
        end
    end

    always_ff @(posedge clkFPGA) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_audio_dac_tx.sv
// Directed bench for audio_dac_tx: reset, single frame, burst/overflow,
// back-to-back spacing, finish/done and the FIFO empty boundary.
module tb_audio_dac_tx;

    localparam int DATA_W  = 11;
    localparam int DEPTH   = 16;
    localparam int CLK_DIV = 2;
    localparam int FRAME_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] sample_in = '0;
    logic              sample_valid = 1'b0;
    logic              sample_ready;
    logic              finish_in = 1'b0;
    logic              dac_sclk, dac_mosi, dac_cs_n;
    logic              busy, overflow, done;

    always #5 clk = ~clk;

    audio_dac_tx #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .FRAME_W(FRAME_W)
    ) dut (
        .clkFPGA(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .finish_in(finish_in), .dac_sclk(dac_sclk),
        .dac_mosi(dac_mosi), .dac_cs_n(dac_cs_n), .busy(busy), .overflow(overflow),
        .done(done)
    );

    int errors = 0;
    int checks = 0;

    // DAC-side receiver: captures mosi on sclk rising edges while cs_n is low
    logic [15:0] rx_word = '0;
    int          rx_bits = 0, lo_cnt = 0, hi_cnt = 0, gb_cnt = 0, sclk_rises = 0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [15:0] rx_q[$];
    int          nb_q[$], lo_q[$], gap_q[$], gb_q[$];

    always @(negedge clk) begin
        if (dac_sclk && !prev_sclk) sclk_rises++;
        if (dac_cs_n && !prev_cs) begin
            rx_q.push_back(rx_word); nb_q.push_back(rx_bits); lo_q.push_back(lo_cnt);
            rx_word = '0; rx_bits = 0; lo_cnt = 0;
        end
        if (!dac_cs_n && prev_cs) begin
            gap_q.push_back(hi_cnt); hi_cnt = 0;
        end
        if (dac_cs_n) begin
            hi_cnt++;
        end else begin
            lo_cnt++;
            if (dac_sclk && !prev_sclk) begin
                rx_word = {rx_word[14:0], dac_mosi};
                rx_bits++;
            end
        end
        if (dac_cs_n && busy) begin
            gb_cnt++;
        end else if (gb_cnt != 0 && !busy) begin
            gb_q.push_back(gb_cnt); gb_cnt = 0;
        end
        prev_cs   = dac_cs_n;
        prev_sclk = dac_sclk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sample_valid = 1'b0; finish_in = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic clear_mon();
        rx_q.delete(); nb_q.delete(); lo_q.delete(); gap_q.delete(); gb_q.delete();
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin tick(); c++; end
        ok = (rx_q.size() >= n);
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int c = 0;
        while (busy && c < budget) begin tick(); c++; end
        ok = !busy;
    endtask

    function automatic logic [DATA_W-1:0] bv(input int i);
        return DATA_W'(i * 97 + 3);
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (dac_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: got %b want 1", dac_cs_n); end
        checks++; if (dac_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b want 0", dac_sclk); end
        checks++; if (dac_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b want 0", dac_mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", sample_ready); end
    endtask

    task automatic test_single();
        bit ok;
        clear_mon();
        sample_in = 11'h5A5; sample_valid = 1'b1; tick(); sample_valid = 1'b0;
        checks++; if (dac_cs_n !== 1'b1) begin errors++; $display("FAIL single_cs_write_edge: got %b want 1", dac_cs_n); end
        tick();
        checks++; if (dac_cs_n !== 1'b0) begin errors++; $display("FAIL single_latency_cs: got %b want 0", dac_cs_n); end
        wait_frames(1, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got %0d frames want 1", rx_q.size()); end
        wait_idle(20, ok); tick(); tick();
        if (ok && rx_q.size() >= 1 && gb_q.size() >= 1) begin
            checks++; if (rx_q[0] !== 16'h05A5) begin errors++; $display("FAIL single_data: got %h want 05a5", rx_q[0]); end
            checks++; if (nb_q[0] != 16) begin errors++; $display("FAIL single_sclk_rises: got %0d want 16", nb_q[0]); end
            checks++; if (lo_q[0] != 64) begin errors++; $display("FAIL single_cs_low: got %0d want 64", lo_q[0]); end
            checks++; if (gb_q[0] != 2) begin errors++; $display("FAIL single_gap: got %0d want 2", gb_q[0]); end
        end else begin
            checks++; errors++; $display("FAIL single_capture: got frames=%0d gaps=%0d want 1 and 1", rx_q.size(), gb_q.size());
        end
    endtask

    task automatic test_burst();
        bit ok;
        do_reset(); clear_mon();
        for (int i = 0; i < 17; i++) begin
            sample_in = bv(i); sample_valid = 1'b1; tick();
        end
        sample_valid = 1'b0;
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL burst_ready_full: got %b want 0", sample_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL burst_no_overflow: got %b want 0", overflow); end
        sample_in = 11'h7FF; sample_valid = 1'b1; tick(); sample_valid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_overflow: got %b want 1", overflow); end
        wait_frames(17, 17 * 67 + 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_timeout: got %0d frames want 17", rx_q.size()); end
        repeat (100) tick();
        checks++; if (rx_q.size() != 17) begin errors++; $display("FAIL burst_frame_count: got %0d want 17", rx_q.size()); end
        for (int i = 0; i < 17; i++) begin
            if (i < rx_q.size()) begin
                checks++;
                if (rx_q[i] !== {5'b0, bv(i)}) begin
                    errors++; $display("FAIL burst_order[%0d]: got %h want %h", i, rx_q[i], {5'b0, bv(i)});
                end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL burst_overflow_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [15:0] exp [3];
        exp[0] = 16'h0001; exp[1] = 16'h0400; exp[2] = 16'h02AA;
        do_reset(); clear_mon();
        for (int i = 0; i < 3; i++) begin
            sample_in = exp[i][DATA_W-1:0]; sample_valid = 1'b1; tick();
        end
        sample_valid = 1'b0;
        wait_frames(3, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d frames want 3", rx_q.size()); end
        if (ok && gap_q.size() >= 3) begin
            checks++; if (gap_q[1] != 3) begin errors++; $display("FAIL b2b_gap1: got %0d want 3", gap_q[1]); end
            checks++; if (gap_q[2] != 3) begin errors++; $display("FAIL b2b_gap2: got %0d want 3", gap_q[2]); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (rx_q[i] !== exp[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rx_q[i], exp[i]); end
                checks++; if (lo_q[i] != 64) begin errors++; $display("FAIL b2b_cs_low[%0d]: got %0d want 64", i, lo_q[i]); end
            end
        end else begin
            checks++; errors++; $display("FAIL b2b_capture: got gaps=%0d want 3", gap_q.size());
        end
        wait_idle(20, ok); tick(); tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_no_finish: got %b want 0", done); end
    endtask

    task automatic test_finish();
        bit ok, saw_done;
        int c;
        do_reset(); clear_mon();
        sample_in = 11'h123; sample_valid = 1'b1; tick();
        sample_in = 11'h456; tick(); sample_valid = 1'b0;
        finish_in = 1'b1; tick(); finish_in = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL finish_done_pending: got %b want 0", done); end
        saw_done = 1'b0; c = 0;
        while ((rx_q.size() < 2 || busy) && c < 400) begin
            tick(); c++;
            if (done) saw_done = 1'b1;
        end
        checks++; if (c >= 400) begin errors++; $display("FAIL finish_timeout: got %0d frames want 2", rx_q.size()); end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL finish_done_early: got 1 want 0"); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL finish_done_at_idle: got %b want 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL finish_done_set: got %b want 1", done); end
        sample_in = 11'h0F0; sample_valid = 1'b1; tick(); sample_valid = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL finish_done_write_edge: got %b want 1", done); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL finish_done_drop: got %b want 0", done); end
        wait_frames(3, 200, ok);
        wait_idle(20, ok); tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL finish_done_again: got %b want 1", done); end
        if (rx_q.size() == 3) begin
            checks++; if (rx_q[0] !== 16'h0123) begin errors++; $display("FAIL finish_data0: got %h want 0123", rx_q[0]); end
            checks++; if (rx_q[2] !== 16'h00F0) begin errors++; $display("FAIL finish_data2: got %h want 00f0", rx_q[2]); end
        end else begin
            checks++; errors++; $display("FAIL finish_frames: got %0d want 3", rx_q.size());
        end
    endtask

    task automatic test_empty_boundary();
        bit ok;
        do_reset(); clear_mon();
        sample_in = 11'h3C3; sample_valid = 1'b1; tick();
        sample_in = 11'h03C; tick(); sample_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL boundary_busy: got %b want 1", busy); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL boundary_ready: got %b want 1", sample_ready); end
        wait_frames(2, 300, ok);
        repeat (100) tick();
        checks++; if (rx_q.size() != 2) begin errors++; $display("FAIL boundary_count: got %0d want 2", rx_q.size()); end
        if (rx_q.size() >= 2) begin
            checks++; if (rx_q[0] !== 16'h03C3) begin errors++; $display("FAIL boundary_data0: got %h want 03c3", rx_q[0]); end
            checks++; if (rx_q[1] !== 16'h003C) begin errors++; $display("FAIL boundary_data1: got %h want 003c", rx_q[1]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int c, rises0;
        bit cs_seen_low;
        do_reset(); clear_mon();
        sample_in = 11'h7FF; sample_valid = 1'b1; tick();
        sample_in = 11'h555; tick(); sample_valid = 1'b0;
        c = 0;
        while (dac_cs_n && c < 20) begin tick(); c++; end
        checks++; if (dac_cs_n !== 1'b0) begin errors++; $display("FAIL midrst_frame_start: got %b want 0", dac_cs_n); end
        repeat (9) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (dac_cs_n !== 1'b1) begin errors++; $display("FAIL midrst_cs_n: got %b want 1", dac_cs_n); end
        checks++; if (dac_sclk !== 1'b0) begin errors++; $display("FAIL midrst_sclk: got %b want 0", dac_sclk); end
        checks++; if (dac_mosi !== 1'b0) begin errors++; $display("FAIL midrst_mosi: got %b want 0", dac_mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", sample_ready); end
        rises0 = sclk_rises; cs_seen_low = 1'b0;
        repeat (200) begin
            tick();
            if (!dac_cs_n) cs_seen_low = 1'b1;
        end
        checks++; if (sclk_rises != rises0) begin errors++; $display("FAIL midrst_sclk_edges: got %0d want 0", sclk_rises - rises0); end
        checks++; if (cs_seen_low !== 1'b0) begin errors++; $display("FAIL midrst_fifo_empty: got frame want none"); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_back_to_back();
        test_finish();
        test_empty_boundary();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
